// File: rtl/ppu_regfile_pkg.sv
// Shared register-file constants and types for the PPU writeback/context-save path.
package ppu_regfile_pkg;

    localparam int unsigned N_REGS = 32;
    localparam int unsigned IDX_W  = 5;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [N_REGS-1:0] reg_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } enc_state_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// Combinational priority encoder: index of the lowest set bit of a register mask.
module lowest_set_encoder
    import ppu_regfile_pkg::*;
(
    input  reg_mask_t mask,
    output reg_idx_t  idx,
    output logic      any
);

    always_comb begin
        idx = '0;
        // Walk downward so the lowest set bit is the last assignment to stick.
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = reg_idx_t'(i);
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/reg_mask_encoder.sv
// Sequential 32-to-5 encoder: walks a multi-hot register mask, one index per accepted transfer.
// Optional emit counter enabled by defining REG_MASK_ENCODER_COUNT_EN.
module reg_mask_encoder
    import ppu_regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [N_REGS-1:0] mask_in,
    input  logic             flush,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    input  logic             out_ready,
    output logic             busy,
`ifdef REG_MASK_ENCODER_COUNT_EN
    output logic [IDX_W:0]   emit_count,
`endif
    output logic             done
);

    enc_state_t state_q, state_d;
    reg_mask_t  pending_q, pending_d;
    reg_idx_t   low_idx;
    logic       pend_any;
    logic       xfer;
    reg_mask_t  pending_clr;

    lowest_set_encoder u_enc (
        .mask (pending_q),
        .idx  (low_idx),
        .any  (pend_any)
    );

    assign xfer        = (state_q == SCAN) && out_ready;
    assign pending_clr = pending_q & ~(reg_mask_t'(1) << low_idx);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    pending_d = mask_in;
                    state_d   = (mask_in != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (flush) begin
                    state_d   = IDLE;
                    pending_d = '0;
                end else if (!pend_any) begin
                    state_d = DONE;
                end else if (xfer) begin
                    pending_d = pending_clr;
                    if (pending_clr == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                pending_d = '0;
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign idx       = low_idx;
    assign idx_valid = (state_q == SCAN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef REG_MASK_ENCODER_COUNT_EN
    logic [IDX_W:0] count_q, count_d;

    // Counts every handshake, including one that lands on the flush cycle.
    always_comb begin
        count_d = count_q;
        if (state_q == IDLE && load) begin
            count_d = '0;
        end else if (xfer) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign emit_count = count_q;
`endif

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Directed self-checking bench for reg_mask_encoder.
module tb_reg_mask_encoder;

    logic        clk;
    logic        reset;
    logic        load;
    logic [31:0] mask_in;
    logic        flush;
    logic [4:0]  idx;
    logic        idx_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef REG_MASK_ENCODER_COUNT_EN
    logic [5:0]  emit_count;
`endif

    int total;
    int bad;

    reg_mask_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .mask_in    (mask_in),
        .flush      (flush),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef REG_MASK_ENCODER_COUNT_EN
        .emit_count (emit_count),
`endif
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks valid/idx/busy/done against expected values in one go.
    task automatic expect_out(input string name, input logic ev, input logic [4:0] ei,
                              input logic eb, input logic ed);
        total++;
        if (idx_valid !== ev || busy !== eb || done !== ed || (ev && idx !== ei)) begin
            bad++;
            $display("FAIL %s: got valid=%b idx=%0d busy=%b done=%b, want valid=%b idx=%0d busy=%b done=%b",
                     name, idx_valid, idx, busy, done, ev, ei, eb, ed);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; mask_in = '0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        total++;
        if (idx !== 5'd0 || idx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got idx=%0d valid=%b busy=%b done=%b, want all 0",
                     idx, idx_valid, busy, done);
        end
`ifdef REG_MASK_ENCODER_COUNT_EN
        total++;
        if (emit_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_count: got %0d want 0", emit_count);
        end
`endif
    endtask

    task automatic test_basic_walk();
        load = 1'b1; mask_in = 32'h8000_0005; out_ready = 1'b1;
        tick();
        load = 1'b0; mask_in = '0;
        expect_out("walk_idx0", 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("walk_idx2", 1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        expect_out("walk_idx31", 1'b1, 5'd31, 1'b1, 1'b0);
        tick();
        expect_out("walk_done", 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        expect_out("walk_idle", 1'b0, 5'd0, 1'b0, 1'b0);
`ifdef REG_MASK_ENCODER_COUNT_EN
        total++;
        if (emit_count !== 6'd3) begin
            bad++;
            $display("FAIL walk_count: got %0d want 3", emit_count);
        end
`endif
    endtask

    task automatic test_empty_mask();
        load = 1'b1; mask_in = 32'h0; out_ready = 1'b1;
        tick();
        load = 1'b0;
        expect_out("empty_done", 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        expect_out("empty_idle", 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("empty_stay_idle", 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        load = 1'b1; mask_in = 32'h0000_0110; out_ready = 1'b0;
        tick();
        load = 1'b0; mask_in = '0;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("stall_%0d", i), 1'b1, 5'd4, 1'b1, 1'b0);
            tick();
        end
        expect_out("stall_hold", 1'b1, 5'd4, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        expect_out("stall_idx8", 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        expect_out("stall_done", 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        expect_out("stall_idle", 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_full_mask();
        int done_cnt;
        int order_bad;
        done_cnt  = 0;
        order_bad = 0;
        load = 1'b1; mask_in = 32'hFFFF_FFFF; out_ready = 1'b1;
        tick();
        load = 1'b0; mask_in = '0;
        for (int i = 0; i < 32; i++) begin
            if (idx_valid !== 1'b1 || idx !== 5'(i)) begin
                order_bad++;
                $display("FAIL full_idx_%0d: got valid=%b idx=%0d want valid=1 idx=%0d",
                         i, idx_valid, idx, i);
            end
            if (done === 1'b1) done_cnt++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) done_cnt++;
            tick();
        end
        total++;
        if (order_bad != 0) bad++;
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL full_done_count: got %0d want 1", done_cnt);
        end
        expect_out("full_idle", 1'b0, 5'd0, 1'b0, 1'b0);
`ifdef REG_MASK_ENCODER_COUNT_EN
        total++;
        if (emit_count !== 6'd32) begin
            bad++;
            $display("FAIL full_count: got %0d want 32", emit_count);
        end
`endif
    endtask

    task automatic test_flush();
        load = 1'b1; mask_in = 32'h0000_00F0; out_ready = 1'b1;
        tick();
        // Second load while busy must be ignored.
        load = 1'b1; mask_in = 32'h0000_0001;
        expect_out("flush_idx4", 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        load = 1'b0; mask_in = '0;
        expect_out("flush_idx5", 1'b1, 5'd5, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_out("flush_idle", 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        expect_out("flush_no_done", 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_load_flush_idle();
        load = 1'b1; flush = 1'b1; mask_in = 32'h0000_0002; out_ready = 1'b1;
        tick();
        load = 1'b0; flush = 1'b0; mask_in = '0;
        expect_out("loadflush_idx1", 1'b1, 5'd1, 1'b1, 1'b0);
        tick();
        expect_out("loadflush_done", 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid_walk();
        load = 1'b1; mask_in = 32'h0000_0300; out_ready = 1'b0;
        tick();
        load = 1'b0; mask_in = '0;
        expect_out("rst_scan_idx8", 1'b1, 5'd8, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (idx !== 5'd0 || idx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_state: got idx=%0d valid=%b busy=%b done=%b, want all 0",
                     idx, idx_valid, busy, done);
        end
        tick();
        expect_out("rst_no_done", 1'b0, 5'd0, 1'b0, 1'b0);
        load = 1'b1; mask_in = 32'h0000_0001; out_ready = 1'b1;
        tick();
        load = 1'b0; mask_in = '0;
        expect_out("rst_after_idx0", 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("rst_after_done", 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        expect_out("rst_after_idle", 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_walk();
        test_empty_mask();
        test_backpressure();
        test_full_mask();
        test_flush();
        test_load_flush_idle();
        test_reset_mid_walk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_mask_encoder.md
Name: reg_mask_encoder

Overview:
- Sequential 32-to-5 encoder; functional inverse of the register-file write decoder.
- Accepts a multi-hot register mask, one bit per architectural register, e.g. a dirty/pending-writeback set.
- Emits each set bit's 5-bit register index, lowest index first, over a valid/ready stream.
- Used by the PPU writeback/context-save path to walk register sets one index per accepted transfer.

Parameters:
- N_REGS, 32, number of registers (mask width).
- IDX_W, 5, index width; must equal clog2(N_REGS).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  start a walk; samples mask_in; accepted only in IDLE.
- mask_in  input  N_REGS  register set to walk; bit k set means index k is emitted.
- flush  input  1  synchronous cancel of the walk in progress.
- idx  output  IDX_W  current register index.
- idx_valid  output  1  idx is valid.
- out_ready  input  1  consumer accepts idx this cycle.
- busy  output  1  walk in progress (state != IDLE).
- done  output  1  one-cycle pulse: walk completed normally.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: idx=0, idx_valid=0, busy=0, done=0; internal pending mask = 0; state = IDLE.
- State machine with three states: IDLE, SCAN, DONE.
- IDLE:
  - load=1 and mask_in!=0: pending<=mask_in; go to SCAN.
  - load=1 and mask_in==0: go to DONE directly (empty walk still produces a done pulse).
  - load=0: stay in IDLE.
- SCAN:
  - idx_valid=1.
  - idx = index of lowest set bit of pending, from a combinational priority encoder on the registered pending mask.
  - Latency: load in cycle N puts the first idx_valid in cycle N+1.
  - Transfer occurs when idx_valid && out_ready. On transfer, pending<=pending & ~(1<<idx).
  - If the transferred bit was the last set bit, go to DONE; else stay in SCAN. The next index is presented the following cycle.
  - Maximum throughput: one index per cycle.
  - While out_ready=0, idx and idx_valid hold stable (no retraction, no change).
- DONE: done=1 for exactly one cycle, idx_valid=0, busy=1; then go to IDLE.
- flush=1 in SCAN or DONE: next state IDLE, pending<=0, no done pulse.
  - A transfer coincident with flush is still counted as accepted by the consumer. The block takes no further action for it.
- flush in IDLE: no effect.
- Simultaneous load and flush in IDLE: load wins.
- load while busy: ignored; mask_in is not sampled.
- reset has priority over flush and load; reset mid-walk aborts with no done pulse.
- Bit N_REGS-1 is emitted as idx = N_REGS-1 (31); there is no wrap-around.

Optional Feature:
- Macro: REG_MASK_ENCODER_COUNT_EN.
- Defined:
  - Adds output emit_count, width IDX_W+1 (6 bits).
  - Cleared to 0 on reset and on an accepted load.
  - Increments on each transfer.
  - Holds its value through DONE and IDLE until the next load, so the final value (0..32) is readable after done.
  - flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ppu_regfile_pkg holds:
  - constants N_REGS=32 and IDX_W=5;
  - typedef reg_idx_t (logic [IDX_W-1:0]);
  - typedef reg_mask_t (logic [N_REGS-1:0]);
  - enum enc_state_t {IDLE, SCAN, DONE}.
- One natural sub-module: lowest_set_encoder.
  - Purely combinational.
  - Inputs: mask.
  - Outputs: idx of lowest set bit, and any (mask!=0).
  - Instantiated once on the pending register.

Test Plan:
- Reset, then load mask_in=0x8000_0005 with out_ready=1 -> idx 0, 2, 31 in consecutive cycles starting the cycle after load; done pulses the cycle after 31; busy=0 the cycle after that.
- load mask_in=0x0000_0000 -> no idx_valid, done=1 exactly one cycle after load, then IDLE.
- load 0x0000_0110, hold out_ready=0 for 3 cycles -> idx=4 stable with idx_valid=1 throughout; release -> 4 then 8 transferred, then done.
- load 0xFFFF_FFFF with out_ready=1 -> 32 transfers, idx 0..31 in order, done once; with REG_MASK_ENCODER_COUNT_EN, emit_count=32 after done.
- Mid-walk flush after two transfers of 0x0000_00F0 -> idx 4, 5 emitted; next cycle busy=0, idx_valid=0, no done; a second load while busy earlier in the walk is ignored.
- Assert reset in SCAN with pending=0x0000_0300 -> next cycle all outputs at reset values; a subsequent load of 0x1 emits idx 0 normally.
